// File: rtl/twd_trans_unroll.sv
// twd_trans_unroll: unrolls a (possibly 2D) transfer into a sequence of 1D rows.
// Optional row-emission counter is built when TWD_TRANS_UNROLL_PERF_CNT_EN is defined.
`default_nettype none

module twd_trans_unroll #(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned LEN_WIDTH           = 16,
    parameter int unsigned TWD_QUEUE_ADD_WIDTH = 2,
    parameter int unsigned TWD_QUEUE_WIDTH     = 2 * LEN_WIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,

    input  logic                           trans_valid_i,
    output logic                           trans_ready_o,
    input  logic [ADDR_WIDTH-1:0]          trans_addr_i,
    input  logic [LEN_WIDTH-1:0]           trans_len_i,
    input  logic                           trans_twd_i,
    input  logic [TWD_QUEUE_ADD_WIDTH-1:0] trans_twd_add_i,

    output logic                           twd_rd_req_o,
    output logic [TWD_QUEUE_ADD_WIDTH-1:0] twd_rd_add_o,
    input  logic [TWD_QUEUE_WIDTH-1:0]     twd_rd_dat_i,

    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [ADDR_WIDTH-1:0]          out_addr_o,
    output logic [LEN_WIDTH-1:0]           out_len_o,
    output logic                           out_last_o,

    output logic [31:0]                    perf_rows_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    state_e                 state;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [LEN_WIDTH-1:0]   remaining;
    logic [LEN_WIDTH-1:0]   row_len;
    logic [LEN_WIDTH-1:0]   stride;

    logic                   accept;
    logic                   row_handshake;
    logic [LEN_WIDTH-1:0]   cap_row_len;
    logic [LEN_WIDTH-1:0]   cap_stride;
    logic                   row_is_last;
    logic [LEN_WIDTH-1:0]   row_cur_len;
    logic [ADDR_WIDTH-1:0]  stride_ext;

    assign accept        = trans_valid_i && (state == IDLE);
    assign row_handshake = (state == EMIT) && out_ready_i;

    // The queue entry is consumed (read and released) in the accepting cycle only.
    assign twd_rd_req_o  = accept && trans_twd_i;
    assign twd_rd_add_o  = trans_twd_add_i;

    // A zero row length in the queue would never finish; treat it as a single row.
    always_comb begin
        cap_row_len = trans_len_i;
        cap_stride  = '0;
        if (trans_twd_i) begin
            cap_row_len = twd_rd_dat_i[LEN_WIDTH-1:0];
            cap_stride  = twd_rd_dat_i[2*LEN_WIDTH-1:LEN_WIDTH];
        end
        if (cap_row_len == '0) begin
            cap_row_len = trans_len_i;
        end
    end

    assign row_is_last = (remaining <= row_len);
    assign row_cur_len = row_is_last ? remaining : row_len;

    generate
        if (ADDR_WIDTH > LEN_WIDTH) begin : g_stride_ext
            assign stride_ext = {{(ADDR_WIDTH - LEN_WIDTH){1'b0}}, stride};
        end else begin : g_stride_trunc
            assign stride_ext = stride[ADDR_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            row_len   <= '0;
            stride    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_addr  <= trans_addr_i;
                        remaining <= trans_len_i;
                        row_len   <= cap_row_len;
                        stride    <= cap_stride;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (row_handshake) begin
                        if (row_is_last) begin
                            state <= IDLE;
                        end else begin
                            remaining <= remaining - row_cur_len;
                            cur_addr  <= cur_addr + stride_ext;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Row outputs are forced to zero outside EMIT so reset clears them at once.
    assign trans_ready_o = (state == IDLE);
    assign out_valid_o   = (state == EMIT);
    assign out_addr_o    = (state == EMIT) ? cur_addr    : '0;
    assign out_len_o     = (state == EMIT) ? row_cur_len : '0;
    assign out_last_o    = (state == EMIT) && row_is_last;

`ifdef TWD_TRANS_UNROLL_PERF_CNT_EN
    logic [31:0] perf_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_cnt <= '0;
        end else if (row_handshake) begin
            perf_cnt <= perf_cnt + 32'd1;
        end
    end

    assign perf_rows_o = perf_cnt;
`else
    assign perf_rows_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_twd_trans_unroll.sv
// tb_twd_trans_unroll: directed stimulus with a row scoreboard checked by an output monitor.
`default_nettype none

module tb_twd_trans_unroll;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] len;
        logic        last;
    } row_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        trans_valid_i = 1'b0;
    logic        trans_ready_o;
    logic [31:0] trans_addr_i = '0;
    logic [15:0] trans_len_i = '0;
    logic        trans_twd_i = 1'b0;
    logic [1:0]  trans_twd_add_i = '0;
    logic        twd_rd_req_o;
    logic [1:0]  twd_rd_add_o;
    logic [31:0] twd_rd_dat_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] out_addr_o;
    logic [15:0] out_len_o;
    logic        out_last_o;
    logic [31:0] perf_rows_o;

    int   tests = 0;
    int   fails = 0;
    int   req_seen = 0;
    int   req_exp = 0;
    int   perf_exp = 0;
    row_t sb[$];

    twd_trans_unroll dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .trans_valid_i   (trans_valid_i),
        .trans_ready_o   (trans_ready_o),
        .trans_addr_i    (trans_addr_i),
        .trans_len_i     (trans_len_i),
        .trans_twd_i     (trans_twd_i),
        .trans_twd_add_i (trans_twd_add_i),
        .twd_rd_req_o    (twd_rd_req_o),
        .twd_rd_add_o    (twd_rd_add_o),
        .twd_rd_dat_i    (twd_rd_dat_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_addr_o      (out_addr_o),
        .out_len_o       (out_len_o),
        .out_last_o      (out_last_o),
        .perf_rows_o     (perf_rows_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] perf_model();
`ifdef TWD_TRANS_UNROLL_PERF_CNT_EN
        return 32'(perf_exp);
`else
        return 32'd0;
`endif
    endfunction

    // Monitor: every row handshake is matched against the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && twd_rd_req_o) req_seen++;
        if (rst_ni && out_valid_o && out_ready_i) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_row: got addr 0x%0h len %0d, expected no row", out_addr_o, out_len_o);
            end else begin
                row_t e;
                e = sb.pop_front();
                chk("row_addr", 64'(out_addr_o), 64'(e.addr));
                chk("row_len",  64'(out_len_o),  64'(e.len));
                chk("row_last", 64'(out_last_o), 64'(e.last));
            end
        end
    end

    function automatic void push_row(input logic [31:0] a, input logic [15:0] l, input logic last);
        row_t r;
        r.addr = a;
        r.len  = l;
        r.last = last;
        sb.push_back(r);
    endfunction

    // Called one time unit after a rising edge with the DUT idle.
    task automatic send(input logic [31:0] addr, input logic [15:0] len, input logic twd,
                        input logic [1:0] add, input logic [31:0] entry);
        trans_valid_i   = 1'b1;
        trans_addr_i    = addr;
        trans_len_i     = len;
        trans_twd_i     = twd;
        trans_twd_add_i = add;
        twd_rd_dat_i    = entry;
        if (twd) req_exp++;
        @(negedge clk_i);
        chk("accept_ready", 64'(trans_ready_o), 64'd1);
        chk("rd_req",       64'(twd_rd_req_o),  64'(twd));
        chk("rd_add",       64'(twd_rd_add_o),  64'(add));
        @(posedge clk_i);
        #1;
        trans_valid_i = 1'b0;
        twd_rd_dat_i  = 32'hDEAD_BEEF;
        chk("first_row_latency", 64'(out_valid_o), 64'd1);
        chk("busy_not_ready",    64'(trans_ready_o), 64'd0);
    endtask

    task automatic wait_done(input string name, input int rows);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk_i);
            if (sb.size() == 0 && !out_valid_o) done = 1'b1;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        perf_exp += rows;
        chk({name, "_req_cnt"}, 64'(req_seen), 64'(req_exp));
        chk({name, "_perf"},    64'(perf_rows_o), 64'(perf_model()));
        chk({name, "_idle_ready"}, 64'(trans_ready_o), 64'd1);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset state, sampled while reset is held
        #12;
        chk("rst_ready", 64'(trans_ready_o), 64'd1);
        chk("rst_valid", 64'(out_valid_o),   64'd0);
        chk("rst_req",   64'(twd_rd_req_o),  64'd0);
        chk("rst_addr",  64'(out_addr_o),    64'd0);
        chk("rst_len",   64'(out_len_o),     64'd0);
        chk("rst_last",  64'(out_last_o),    64'd0);
        chk("rst_perf",  64'(perf_rows_o),   64'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // 1D single row
        push_row(32'h0000_1000, 16'd100, 1'b1);
        send(32'h0000_1000, 16'd100, 1'b0, 2'd3, 32'h0040_0040);
        wait_done("oned", 1);

        // 2D: four rows, stride 128
        push_row(32'h0000_2000, 16'd64, 1'b0);
        push_row(32'h0000_2080, 16'd64, 1'b0);
        push_row(32'h0000_2100, 16'd64, 1'b0);
        push_row(32'h0000_2180, 16'd64, 1'b1);
        send(32'h0000_2000, 16'd256, 1'b1, 2'd2, {16'd128, 16'd64});
        wait_done("twod", 4);

        // Partial tail row
        push_row(32'h0000_0000, 16'd64, 1'b0);
        push_row(32'h0000_0040, 16'd36, 1'b1);
        send(32'h0000_0000, 16'd100, 1'b1, 2'd1, {16'd64, 16'd64});
        wait_done("tail", 2);

        // Address wrap
        push_row(32'hFFFF_FFC0, 16'd64, 1'b0);
        push_row(32'h0000_0040, 16'd64, 1'b1);
        send(32'hFFFF_FFC0, 16'd128, 1'b1, 2'd0, {16'h0080, 16'd64});
        wait_done("wrap", 2);

        // Zero row length from the queue degenerates to a single row
        push_row(32'h0000_7000, 16'd48, 1'b1);
        send(32'h0000_7000, 16'd48, 1'b1, 2'd3, {16'h0010, 16'd0});
        wait_done("rowlen0", 1);

        // Zero-length transfer
        push_row(32'h0000_8000, 16'd0, 1'b1);
        send(32'h0000_8000, 16'd0, 1'b0, 2'd0, 32'h0);
        wait_done("len0", 1);

        // Backpressure: first row held for three cycles
        out_ready_i = 1'b0;
        push_row(32'h0000_3000, 16'd64, 1'b0);
        push_row(32'h0000_3100, 16'd64, 1'b0);
        push_row(32'h0000_3200, 16'd64, 1'b1);
        send(32'h0000_3000, 16'd192, 1'b1, 2'd1, {16'h0100, 16'd64});
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("bp_valid", 64'(out_valid_o),   64'd1);
            chk("bp_ready", 64'(trans_ready_o), 64'd0);
            chk("bp_addr",  64'(out_addr_o),    64'h3000);
            chk("bp_len",   64'(out_len_o),     64'd64);
            chk("bp_last",  64'(out_last_o),    64'd0);
        end
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b1;
        wait_done("bp", 3);

        // Reset after the first of four rows
        rst_ni = 1'b0;
        #2;
        rst_ni = 1'b1;
        perf_exp = 0;
        @(posedge clk_i);
        #1;
        push_row(32'h0000_5000, 16'd64, 1'b0);
        push_row(32'h0000_5040, 16'd64, 1'b0);
        push_row(32'h0000_5080, 16'd64, 1'b0);
        push_row(32'h0000_50C0, 16'd64, 1'b1);
        send(32'h0000_5000, 16'd256, 1'b1, 2'd2, {16'h0040, 16'd64});
        @(posedge clk_i);
        #1;
        perf_exp = 1;
        chk("pre_rst_perf",  64'(perf_rows_o), 64'(perf_model()));
        chk("pre_rst_valid", 64'(out_valid_o), 64'd1);
        rst_ni = 1'b0;
        sb.delete();
        #1;
        chk("mid_rst_valid", 64'(out_valid_o),   64'd0);
        chk("mid_rst_ready", 64'(trans_ready_o), 64'd1);
        chk("mid_rst_perf",  64'(perf_rows_o),   64'd0);
        chk("mid_rst_addr",  64'(out_addr_o),    64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        perf_exp = 0;
        wait_done("post_rst", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/twd_trans_unroll.md
TWD_TRANS_UNROLL -- requirements
Module: twd_trans_unroll

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, transfer address width.
REQ-002 SHALL have parameter LEN_WIDTH, default 16, byte-length and stride width.
REQ-003 SHALL have parameter TWD_QUEUE_ADD_WIDTH, default 2, 2D queue index width.
REQ-004 SHALL have parameter TWD_QUEUE_WIDTH, default 2*LEN_WIDTH, 2D queue entry width; entry = {stride[2*LEN_WIDTH-1:LEN_WIDTH], row_len[LEN_WIDTH-1:0]}.
REQ-005 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset, asynchronous, active-low.
REQ-006 trans_valid_i in 1, trans_ready_o out 1: incoming transfer handshake.
REQ-007 trans_addr_i in ADDR_WIDTH base address; trans_len_i in LEN_WIDTH total bytes; trans_twd_i in 1, 1 = 2D transfer; trans_twd_add_i in TWD_QUEUE_ADD_WIDTH 2D queue index.
REQ-008 twd_rd_req_o out 1 read-and-release strobe; twd_rd_add_o out TWD_QUEUE_ADD_WIDTH index; twd_rd_dat_i in TWD_QUEUE_WIDTH entry, combinational same-cycle read data.
REQ-009 out_valid_o out 1, out_ready_i in 1: 1D row handshake; out_addr_o out ADDR_WIDTH; out_len_o out LEN_WIDTH; out_last_o out 1, final row of transfer.
REQ-010 perf_rows_o out 32: count of emitted rows (see Configuration).

Function
REQ-011 SHALL implement FSM with states IDLE and EMIT.
REQ-012 IDLE: trans_ready_o=1, out_valid_o=0; EMIT: trans_ready_o=0, out_valid_o=1.
REQ-013 Acceptance = trans_valid_i & trans_ready_o; on acceptance SHALL load cur_addr=trans_addr_i, remaining=trans_len_i and enter EMIT next cycle.
REQ-014 On acceptance with trans_twd_i=1: twd_rd_req_o=1 for exactly that cycle, twd_rd_add_o=trans_twd_add_i, row_len and stride captured from twd_rd_dat_i that cycle.
REQ-015 On acceptance with trans_twd_i=0: twd_rd_req_o SHALL stay 0; row_len=trans_len_i, stride=0.
REQ-016 twd_rd_req_o SHALL be 0 in every cycle without a 2D acceptance; twd_rd_add_o=trans_twd_add_i at all times.
REQ-017 Captured row_len=0 SHALL be replaced by trans_len_i (single row; no hang).
REQ-018 EMIT outputs: out_addr_o=cur_addr; out_len_o=min(row_len, remaining); out_last_o=(remaining<=row_len).
REQ-019 out_addr_o/out_len_o/out_last_o SHALL be stable while out_valid_o=1 and out_ready_i=0.
REQ-020 On out handshake with out_last_o=0: remaining-=out_len_o, cur_addr+=zero-extended stride modulo 2^ADDR_WIDTH, stay EMIT.
REQ-021 On out handshake with out_last_o=1: return to IDLE; new transfer accepted no earlier than following cycle (one idle cycle minimum between transfers).
REQ-022 trans_len_i=0 SHALL produce exactly one row with out_len_o=0, out_last_o=1.
REQ-023 First row SHALL appear with out_valid_o=1 one cycle after acceptance.

Reset
REQ-024 On rst_ni=0 state SHALL go IDLE immediately: trans_ready_o=1, out_valid_o=0, twd_rd_req_o=0 (when trans_valid_i=0), out_addr_o=0, out_len_o=0, out_last_o=0, perf_rows_o=0.
REQ-025 Reset mid-EMIT SHALL abandon the transfer with no further rows and no further queue reads.

Configuration
REQ-026 Macro TWD_TRANS_UNROLL_PERF_CNT_EN defined: perf_rows_o SHALL increment by 1 per out handshake, wrapping at 2^32.
REQ-027 Macro undefined: perf_rows_o SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-028 1D: addr 0x1000, len 100, twd=0, out_ready=1 -> one row 0x1000/100/last=1; twd_rd_req_o never asserted.
REQ-029 2D: addr 0x2000, len 256, entry row_len=64 stride=128, add=2 -> twd_rd_req_o 1-cycle pulse with add 2; rows 0x2000,0x2080,0x2100,0x2180 len 64, last only on 4th.
REQ-030 Partial tail: len 100, row_len=64, stride=64, base 0 -> rows 0x0/64 and 0x40/36 last=1.
REQ-031 Backpressure: out_ready_i=0 for 3 cycles in EMIT -> outputs held constant, trans_ready_o=0; then proceeds unchanged.
REQ-032 Wrap/degenerate: base 0xFFFF_FFC0, len 128, row_len 64, stride 0x80 -> second row addr 0x0000_0040; separate run with row_len=0, len 48 -> single row len 48 last=1.
REQ-033 Reset after first of 4 rows -> out_valid_o=0 immediately, trans_ready_o=1, perf_rows_o=0; with macro defined, count before reset = 1.
